// File: rtl/def_pkg.sv
// Shared definitions for the ALU round-robin scheduler: opcodes, FSM states,
// the watchdog abort result and the opcode legality check.
package def_pkg;

   // ALU opcodes; 3'b101 and 3'b110 are unassigned and treated as illegal.
   typedef enum logic [2:0] {
      NO_OP  = 3'b000,
      ADD_OP = 3'b001,
      AND_OP = 3'b010,
      XOR_OP = 3'b011,
      MUL_OP = 3'b100,
      RST_OP = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } alu_sched_state_t;

   // Result returned when the watchdog aborts an operation.
   localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

   // Only these opcodes are ever forwarded to the ALU.
   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         ADD_OP, AND_OP, XOR_OP, MUL_OP: is_legal_op = 1'b1;
         default:                        is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               valid,
   output logic [PTR_W-1:0]   idx
);

   int cand;

   // Scan the requests in rotated order, keep the first hit.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = PTR_W'(cand);
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin accept, operand
// latching, start/done handshake, per-requester response, watchdog abort.
module alu_rr_scheduler
   import def_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   input  logic [3*NUM_REQ-1:0]   req_op,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [15:0]            rsp_result,
   output logic                   rsp_err,
   output logic [7:0]             alu_a,
   output logic [7:0]             alu_b,
   output logic [2:0]             alu_op,
   output logic                   alu_start,
   input  logic                   alu_done,
   input  logic [15:0]            alu_result,
   output logic                   busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   // Watchdog only needs to reach TIMEOUT-1: the abort fires on that count.
   localparam int WD_W  = $clog2(TIMEOUT);

   alu_sched_state_t state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] owner;
   logic [WD_W-1:0]  wd;

   logic [NUM_REQ-1:0]       pick_oh;
   logic                     pick_vld;
   logic [PTR_W-1:0]         pick_idx;
   logic [NUM_REQ-1:0][7:0]  a_v;
   logic [NUM_REQ-1:0][7:0]  b_v;
   logic [NUM_REQ-1:0][2:0]  op_v;
   logic [NUM_REQ-1:0]       owner_oh;
   logic [PTR_W-1:0]         ptr_next;

   assign a_v  = req_a;
   assign b_v  = req_b;
   assign op_v = req_op;

   assign owner_oh = NUM_REQ'(1) << owner;
   assign ptr_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   assign busy     = (state != IDLE);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .gnt   (pick_oh),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Scheduler FSM; every output it drives is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         wd         <= '0;
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= NO_OP;
         alu_start  <= 1'b0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  owner <= pick_idx;
                  gnt   <= pick_oh;
                  wd    <= '0;
                  if (is_legal_op(op_v[pick_idx])) begin
                     alu_a     <= a_v[pick_idx];
                     alu_b     <= b_v[pick_idx];
                     alu_op    <= op_v[pick_idx];
                     alu_start <= 1'b1;
                     state     <= RUN;
                  end else begin
                     // Illegal op bypasses the ALU; the response follows a
                     // cycle later so it never coincides with the grant.
                     rsp_err    <= 1'b1;
                     rsp_result <= '0;
                     state      <= RESP;
                  end
               end
            end
            RUN: begin
               if (alu_done) begin
                  alu_start  <= 1'b0;
                  rsp_result <= alu_result;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= owner_oh;
                  state      <= RESP;
               end else if (wd == WD_W'(TIMEOUT - 1)) begin
                  alu_start  <= 1'b0;
                  rsp_result <= TIMEOUT_RESULT;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= owner_oh;
                  state      <= RESP;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            RESP: begin
               if (rsp_valid == '0) begin
                  rsp_valid <= owner_oh;
               end else begin
                  rsp_valid  <= '0;
                  rsp_err    <= 1'b0;
                  rsp_result <= '0;
                  ptr        <= ptr_next;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed vector table, hand-written arbitration
// and reset sequences, and a random phase against a transaction-level model.
module tb_alu_rr_scheduler;

   localparam int NR = 4;
   localparam int TO = 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NR-1:0]       req = '0;
   logic [NR-1:0][7:0]  ra = '0;
   logic [NR-1:0][7:0]  rb = '0;
   logic [NR-1:0][2:0]  rop = '0;
   logic [NR-1:0]       gnt;
   logic [NR-1:0]       rsp_valid;
   logic [15:0]         rsp_result;
   logic                rsp_err;
   logic [7:0]          alu_a;
   logic [7:0]          alu_b;
   logic [2:0]          alu_op;
   logic                alu_start;
   logic                alu_done = 1'b0;
   logic [15:0]         alu_result = '0;
   logic                busy;

   int n_chk = 0;
   int n_fail = 0;
   int lat_cfg = 1;
   bit spur_en = 1'b0;
   int cur_lat = 0;
   int st_cnt = 0;
   logic [7:0] sv_a, sv_b;
   logic [2:0] sv_op;
   bit mon_en = 1'b0;
   int cyc = 0;
   int last_g = -100;

   typedef struct {
      int          who;
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      int          lat;
      logic [15:0] exp_res;
      logic        exp_err;
      int          exp_starts;
   } vec_t;

   vec_t vt[11];

   always #5 clk = ~clk;

   alu_rr_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_a      (ra),
      .req_b      (rb),
      .req_op     (rop),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .busy       (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd1:    alu_ref = 16'(a) + 16'(b);
         3'd2:    alu_ref = {8'h00, a & b};
         3'd3:    alu_ref = {8'h00, a ^ b};
         3'd4:    alu_ref = 16'(a) * 16'(b);
         default: alu_ref = 16'h0000;
      endcase
   endfunction

   function automatic bit legal(input logic [2:0] op);
      return op inside {3'd1, 3'd2, 3'd3, 3'd4};
   endfunction

   function automatic logic [NR-1:0] oh(input int i);
      oh = '0;
      if (i >= 0 && i < NR) oh[i] = 1'b1;
   endfunction

   function automatic int first_idx(input logic [NR-1:0] v);
      first_idx = -1;
      for (int i = NR - 1; i >= 0; i--) if (v[i]) first_idx = i;
   endfunction

   // Requester served next: first one asking, counting from p upward with wrap.
   function automatic int rr_pick(input logic [NR-1:0] r, input int p);
      rr_pick = -1;
      for (int k = 0; k < NR; k++)
         if (rr_pick < 0 && r[(p + k) % NR]) rr_pick = (p + k) % NR;
   endfunction

   // ALU stand-in: done after cur_lat start-high cycles (0 = never).
   always @(negedge clk) begin
      if (alu_start) begin
         if (st_cnt == 0) begin
            cur_lat = (lat_cfg >= 0) ? lat_cfg :
                      (($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 4)));
            sv_a = alu_a; sv_b = alu_b; sv_op = alu_op;
            chk("alu_op_legal", 32'(legal(alu_op)), 32'd1);
         end else begin
            chk("alu_operands_stable", 32'({alu_op, alu_a, alu_b}), 32'({sv_op, sv_a, sv_b}));
         end
         st_cnt++;
         alu_done   = (cur_lat != 0) && (st_cnt == cur_lat);
         alu_result = alu_ref(alu_a, alu_b, alu_op);
      end else begin
         st_cnt     = 0;
         alu_done   = spur_en && ($urandom_range(0, 3) == 0);
         alu_result = 16'($urandom);
      end
   end

   // Output-wide invariants: one-hot pulses, never together, grants >=3 apart.
   always @(negedge clk) begin
      cyc++;
      if (mon_en && rst_n) begin
         chk("onehot_excl", 32'({$onehot0(gnt), $onehot0(rsp_valid), !(|gnt && |rsp_valid)}), 32'd7);
         if (|gnt) begin
            chk("gnt_gap", 32'((cyc - last_g) >= 3), 32'd1);
            last_g = cyc;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_out(input bit sel_rsp, output logic [NR-1:0] v);
      int n;
      bit got;
      v = '0; n = 0; got = 1'b0;
      while (!got && n < 80) begin
         @(negedge clk);
         n++;
         v = sel_rsp ? rsp_valid : gnt;
         got = |v;
      end
   endtask

   task automatic do_single(input vec_t v);
      int n, starts;
      lat_cfg = v.lat;
      chk("idle_not_busy", 32'(busy), 32'd0);
      ra[v.who] = v.a; rb[v.who] = v.b; rop[v.who] = v.op;
      req = oh(v.who);
      n = 0;
      while (!(|gnt) && n < 10) begin @(negedge clk); n++; end
      chk("gnt_vector", 32'(gnt), 32'(oh(v.who)));
      chk("gnt_latency", 32'(n), 32'd1);
      req = '0;
      starts = 0; n = 0;
      while (!(|rsp_valid) && n < 80) begin
         if (alu_start) starts++;
         @(negedge clk);
         n++;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(oh(v.who)));
      chk("rsp_result", 32'(rsp_result), 32'(v.exp_res));
      chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      chk("start_cycles", 32'(starts), 32'(v.exp_starts));
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "global timeout");
   end

   initial begin
      int ev[$];
      int exp1[10];
      int exp2[6];
      int nr, c, w, owner, mptr, ngnt, nrsp;
      logic [NR-1:0] v, prev;
      logic [2:0] o_op;
      logic [7:0] o_a, o_b;
      logic [15:0] e_res;
      logic e_err;
      bit saw;

      //        who op     a      b      lat res       err  starts
      vt[0]  = '{0, 3'd1, 8'hFF, 8'h01, 1,  16'h0100, 1'b0, 1};
      vt[1]  = '{2, 3'd4, 8'hFF, 8'hFF, 3,  16'hFE01, 1'b0, 3};
      vt[2]  = '{1, 3'd0, 8'h12, 8'h34, 1,  16'h0000, 1'b1, 0};
      vt[3]  = '{1, 3'd7, 8'h12, 8'h34, 1,  16'h0000, 1'b1, 0};
      vt[4]  = '{3, 3'd2, 8'hF0, 8'h3C, 2,  16'h0030, 1'b0, 2};
      vt[5]  = '{0, 3'd2, 8'h5A, 8'hA5, 0,  16'hDEAD, 1'b1, 32};
      vt[6]  = '{1, 3'd3, 8'h5A, 8'hFF, 1,  16'h00A5, 1'b0, 1};
      vt[7]  = '{2, 3'd5, 8'h01, 8'h01, 1,  16'h0000, 1'b1, 0};
      vt[8]  = '{3, 3'd4, 8'h02, 8'h80, 32, 16'h0100, 1'b0, 32};
      vt[9]  = '{3, 3'd1, 8'h80, 8'h80, 4,  16'h0100, 1'b0, 4};
      vt[10] = '{0, 3'd6, 8'h77, 8'h88, 1,  16'h0000, 1'b1, 0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt_rsp", 32'({gnt, rsp_valid}), 32'd0);
      chk("rst_result_err", 32'({rsp_result, rsp_err}), 32'd0);
      chk("rst_alu_pins", 32'({alu_a, alu_b, alu_op, alu_start}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      foreach (vt[i]) do_single(vt[i]);

      // All four held: strict rotation, each response before the next grant
      do_reset();
      lat_cfg = 1;
      for (int i = 0; i < NR; i++) begin
         ra[i] = 8'(8'h11 * (i + 1)); rb[i] = 8'h0F; rop[i] = 3'd3;
      end
      req = '1;
      exp1 = '{0, 16, 1, 17, 2, 18, 3, 19, 0, 16};
      nr = 0; c = 0;
      while (nr < 5 && c < 200) begin
         @(negedge clk); c++;
         if (|gnt) ev.push_back(first_idx(gnt));
         if (|rsp_valid) begin
            w = first_idx(rsp_valid);
            ev.push_back(16 + w);
            chk("rr_xor_result", 32'(rsp_result), 32'(alu_ref(ra[w], rb[w], 3'd3)));
            nr++;
            if (nr == 5) req = 4'b1010;
         end
      end
      chk("rr_events", 32'(ev.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         chk("rr_order_all", 32'((i < ev.size()) ? ev[i] : -1), 32'(exp1[i]));

      // Only 1 and 3 asking, pointer now at 1
      ev.delete();
      exp2 = '{1, 17, 3, 19, 1, 17};
      nr = 0; c = 0;
      while (nr < 3 && c < 200) begin
         @(negedge clk); c++;
         if (|gnt) ev.push_back(first_idx(gnt));
         if (|rsp_valid) begin
            ev.push_back(16 + first_idx(rsp_valid));
            nr++;
            if (nr == 3) req = '0;
         end
      end
      for (int i = 0; i < 6; i++)
         chk("rr_order_1_3", 32'((i < ev.size()) ? ev[i] : -1), 32'(exp2[i]));
      @(negedge clk);
      @(negedge clk);

      // Reset in the middle of a hung mul
      do_reset();
      do_single('{1, 3'd1, 8'h01, 8'h02, 1, 16'h0003, 1'b0, 1});
      lat_cfg = 0;
      ra[3] = 8'h0C; rb[3] = 8'h0D; rop[3] = 3'd4;
      req = 4'b1000;
      wait_out(1'b0, v);
      chk("abort_gnt", 32'(v), 32'(4'b1000));
      req = '0;
      repeat (2) @(negedge clk);
      chk("abort_running", 32'(alu_start), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("abort_async_drop", 32'({alu_start, busy}), 32'd0);
      saw = 1'b0;
      repeat (2) begin @(negedge clk); if (|rsp_valid) saw = 1'b1; end
      rst_n = 1'b1;
      chk("abort_no_rsp", 32'(saw), 32'd0);
      lat_cfg = 1;
      ra[0] = 8'h03; rb[0] = 8'h04; rop[0] = 3'd1;
      req = 4'b1001;
      wait_out(1'b0, v);
      chk("post_rst_first", 32'(v), 32'(4'b0001));
      req[0] = 1'b0;
      wait_out(1'b1, v);
      chk("post_rst_rsp0", 32'({v, rsp_result}), 32'({4'b0001, 16'h0007}));
      wait_out(1'b0, v);
      chk("post_rst_second", 32'(v), 32'(4'b1000));
      req[3] = 1'b0;
      wait_out(1'b1, v);
      chk("post_rst_rsp3", 32'({v, rsp_result}), 32'({4'b1000, 16'h009C}));
      @(negedge clk);

      // Random traffic against the transaction-level model
      do_reset();
      spur_en = 1'b1; lat_cfg = -1;
      mptr = 0; owner = -1; ngnt = 0; nrsp = 0; prev = '0;
      o_op = '0; o_a = '0; o_b = '0;
      c = 0;
      while (c < 3000 && (c < 1200 || req != '0 || owner >= 0)) begin
         @(negedge clk); c++;
         if (|gnt) begin
            w = rr_pick(prev, mptr);
            chk("rnd_gnt", 32'(gnt), 32'(oh(w)));
            if (w >= 0) begin
               owner = w; o_op = rop[w]; o_a = ra[w]; o_b = rb[w];
               req[w] = 1'b0;
            end
            ngnt++;
         end
         if (|rsp_valid) begin
            if (owner < 0) begin
               chk("rnd_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               if (!legal(o_op)) begin e_res = 16'h0000; e_err = 1'b1; end
               else if (cur_lat == 0) begin e_res = 16'hDEAD; e_err = 1'b1; end
               else begin e_res = alu_ref(o_a, o_b, o_op); e_err = 1'b0; end
               chk("rnd_rsp_valid", 32'(rsp_valid), 32'(oh(owner)));
               chk("rnd_rsp", 32'({rsp_err, rsp_result}), 32'({e_err, e_res}));
               mptr = (owner + 1) % NR;
               owner = -1;
            end
            nrsp++;
         end
         if (c < 1200) begin
            for (int i = 0; i < NR; i++) begin
               if (!req[i] && $urandom_range(0, 5) == 0) begin
                  req[i] = 1'b1;
                  rop[i] = 3'($urandom_range(0, 7));
                  ra[i]  = 8'($urandom);
                  rb[i]  = 8'($urandom);
               end
            end
         end
         prev = req;
      end
      chk("rnd_drained", 32'(c < 3000), 32'd1);
      chk("rnd_balance", 32'(ngnt), 32'(nrsp));
      chk("rnd_activity", 32'(ngnt > 20), 32'd1);
      spur_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one ALU (A, B, op, start, done, 16-bit result; opcodes from def_pkg operation_t) among NUM_REQ requesters.
- Round-robin arbitration, operand/op latching, start/done sequencing, per-requester result return.
- Watchdog aborts a hung operation.
- Sits between requester agents/blocks and the ALU; the only driver of the ALU input pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 32, max cycles alu_start may stay high without alu_done before abort (>=4)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-requester request level; hold until gnt
req_a  input  8*NUM_REQ  operand A, slice i belongs to requester i
req_b  input  8*NUM_REQ  operand B, slice i
req_op  input  3*NUM_REQ  operation_t opcode, slice i
gnt  output  NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
rsp_result  output  16  result, valid with rsp_valid
rsp_err  output  1  1 = illegal op or timeout, valid with rsp_valid
alu_a  output  8  to ALU A
alu_b  output  8  to ALU B
alu_op  output  3  to ALU op
alu_start  output  1  to ALU start
alu_done  input  1  from ALU done
alu_result  input  16  from ALU result
busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock clk; rst_n asynchronous, active-low.
- Reset values: all outputs 0; alu_op = no_op (3'b000); round-robin pointer = 0; FSM = IDLE; watchdog = 0.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer (wrapping).
  - Legal op (add, and, xor, mul): latch A, B, op into alu_* regs; next cycle gnt[i]=1 and alu_start=1; go to RUN.
  - no_op, rst_op or undefined code: never forwarded to the ALU. Next cycle gnt[i]=1; go to RESP with rsp_err=1 and rsp_result=0.
- RUN:
  - alu_start held at 1 and alu_a/b/op held stable until alu_done is sampled 1.
  - On alu_done=1: capture alu_result, alu_start=0 next cycle, go to RESP.
  - Watchdog counts RUN cycles. If it reaches TIMEOUT with no done: alu_start=0, rsp_err=1, rsp_result=16'hDEAD, go to RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle with rsp_result/rsp_err.
  - Pointer becomes owner+1 mod NUM_REQ; go to IDLE. No arbitration in this cycle.
- Latency:
  - Grant: req seen in IDLE at edge t → gnt and alu_start at t+1.
  - Response: alu_done sampled at edge d → rsp_valid at d+1.
  - Minimum 3-cycle gap between consecutive grants.
- gnt and rsp_valid are never asserted in the same cycle; at most one bit of each is ever set.
- Requester may drop req after gnt and may re-assert immediately; the pointer advance prevents starvation.
- A req bit that drops before gnt is simply not served; no error.
- alu_done while not in RUN: ignored.
- alu_result is sampled only on the done cycle.
- Pointer wraps NUM_REQ-1 → 0.
- Reset mid-RUN: alu_start falls immediately (async). No rsp_valid is produced for the aborted op. Pointer returns to 0.

Decomposition:
- def_pkg: reuse operation_t; add alu_sched_state_t (IDLE, RUN, RESP), TIMEOUT_RESULT = 16'hDEAD, and an is_legal_op() function.
- One sub-module, rr_arbiter: combinational NUM_REQ-wide round-robin pick from req vector plus pointer, returning a one-hot grant and a valid flag.

Test Plan:
- Req0 add A=8'hFF B=8'h01; ALU done 1 cycle after start → gnt[0] at t+1, rsp_valid[0] with rsp_result=16'h0100, rsp_err=0.
- Req2 mul A=8'hFF B=8'hFF; done after 3 cycles → alu_start held 3 cycles with stable operands, rsp_result=16'hFE01.
- All 4 req held with xor ops → grant order 0,1,2,3,0 with each response preceding the next gnt; then req 1,3 only from pointer=1 → order 1,3,1.
- Req1 no_op and req1 rst_op → gnt[1], alu_start never 1, rsp_valid[1] with rsp_err=1, rsp_result=0.
- Req0 and op; ALU never asserts done → alu_start drops after 32 cycles, rsp_err=1, rsp_result=16'hDEAD, next req served normally.
- rst_n low 2 cycles mid-RUN of mul → alu_start 0 asynchronously, no rsp_valid, after release req3 is granted before req0 only if req0 is absent.
